// File: rtl/window_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : window_streamer
//  Description : Reads a WIN x WIN pixel window out of the synchronous frame
//                RAM, starting at a given origin, and streams it line by line
//                to the classifier line buffer. A GAP-cycle pause follows
//                every line except the last. An origin whose window would
//                leave the frame is rejected with a one-cycle ERR pulse.
//  Ports       : CLK, RESET      - clock, asynchronous active-high reset
//                START, X0, Y0   - launch request and window origin
//                BUSY/DONE/ERR   - status (DONE and ERR are 1-cycle pulses)
//                MEM_RD/ADDR/DATA- frame RAM read port (1-cycle read latency)
//                CLS_START, XYZ_VALID, ADDR, XYZ_out - classifier stream
//  Revision    : 1.0 - initial release
// ============================================================================
module window_streamer #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int WIN     = 20,
    parameter int GAP     = 2,
    parameter int DATA_W  = 96
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  START,
    input  logic [$clog2(FRAME_W)-1:0]            X0,
    input  logic [$clog2(FRAME_H)-1:0]            Y0,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic                                  ERR,
    output logic                                  MEM_RD,
    output logic [$clog2(FRAME_W*FRAME_H)-1:0]    MEM_ADDR,
    input  logic [DATA_W-1:0]                     MEM_DATA,
    output logic                                  CLS_START,
    output logic                                  XYZ_VALID,
    output logic [8:0]                            ADDR,
    output logic [DATA_W-1:0]                     XYZ_out
);

    localparam int AW  = $clog2(FRAME_W*FRAME_H);
    localparam int GCW = $clog2(GAP+2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       row_q, row_d;
    logic [8:0]       col_q, col_d;
    logic [AW-1:0]    line_base_q, line_base_d;
    logic [GCW-1:0]   gap_q, gap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mem_rd_q, mem_rd_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    // Read-return pipeline stage: describes the word arriving on MEM_DATA.
    logic             pvalid_q, pvalid_d;
    logic             pfirst_q, pfirst_d;
    logic [8:0]       pcol_q, pcol_d;

    logic             w_origin_bad;
    logic [AW-1:0]    w_launch_base;
    logic             w_last_col;
    logic             w_last_row;

    always_comb begin
        w_origin_bad  = (32'(X0) > 32'(FRAME_W - WIN)) || (32'(Y0) > 32'(FRAME_H - WIN));
        // The only multiply: evaluated once per launch.
        w_launch_base = AW'(Y0) * AW'(FRAME_W) + AW'(X0);
        w_last_col    = (col_q == 9'(WIN - 1));
        w_last_row    = (row_q == 9'(WIN - 1));

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        line_base_d = line_base_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;

        // Counters always describe the read presented in the current cycle,
        // so the next read's address is prepared one cycle ahead here.
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (w_origin_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        row_d       = 9'd0;
                        col_d       = 9'd0;
                        line_base_d = w_launch_base;
                        mem_rd_d    = 1'b1;
                        mem_addr_d  = w_launch_base;
                    end
                end
            end
            S_ISSUE: begin
                if (!w_last_col) begin
                    col_d      = col_q + 9'd1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = line_base_q + AW'(col_q + 9'd1);
                end else begin
                    col_d = 9'd0;
                    if (w_last_row) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d       = row_q + 9'd1;
                        line_base_d = line_base_q + AW'(FRAME_W);
                        if (GAP == 0) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = line_base_q + AW'(FRAME_W);
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GCW'(GAP - 1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d    = S_ISSUE;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = line_base_q;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        pvalid_d = mem_rd_q;
        pfirst_d = mem_rd_q && (row_q == 9'd0) && (col_q == 9'd0);
        pcol_d   = mem_rd_q ? col_q : 9'd0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            row_q       <= 9'd0;
            col_q       <= 9'd0;
            line_base_q <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            pvalid_q    <= 1'b0;
            pfirst_q    <= 1'b0;
            pcol_q      <= 9'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            line_base_q <= line_base_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            pvalid_q    <= pvalid_d;
            pfirst_q    <= pfirst_d;
            pcol_q      <= pcol_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign MEM_RD    = mem_rd_q;
    assign MEM_ADDR  = mem_addr_q;
    assign CLS_START = pfirst_q;
    assign XYZ_VALID = pvalid_q;
    assign ADDR      = pcol_q;
    // RAM data passes straight through in its return cycle; gated to zero
    // otherwise so the output is clean during reset and idle.
    assign XYZ_out   = pvalid_q ? MEM_DATA : '0;

endmodule
`default_nettype wire

// File: tb/tb_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_streamer
//  Description : Self-checking bench for window_streamer. Two instances are
//                built: GAP=2 and GAP=0. Each cycle's outputs are compared
//                against a cycle-indexed model derived from the read schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_streamer;

    localparam int FW  = 640;
    localparam int FH  = 480;
    localparam int WIN = 20;
    localparam int VW  = 130;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [9:0]  in_x0;
    logic [8:0]  in_y0;
    logic [31:0] salt;

    logic        busy_a, done_a, err_a, rd_a, cls_a, val_a;
    logic [18:0] maddr_a;
    logic [95:0] mdata_a, xyz_a;
    logic [8:0]  addr_a;
    logic        busy_b, done_b, err_b, rd_b, cls_b, val_b;
    logic [18:0] maddr_b;
    logic [95:0] mdata_b, xyz_b;
    logic [8:0]  addr_b;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] last_ma;
    logic [31:0] last_xyz;

    window_streamer #(.FRAME_W(FW), .FRAME_H(FH), .WIN(WIN), .GAP(2), .DATA_W(96)) dut_a (
        .CLK(clk), .RESET(rst), .START(start_a), .X0(in_x0), .Y0(in_y0),
        .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .MEM_RD(rd_a), .MEM_ADDR(maddr_a),
        .MEM_DATA(mdata_a), .CLS_START(cls_a), .XYZ_VALID(val_a), .ADDR(addr_a), .XYZ_out(xyz_a)
    );

    window_streamer #(.FRAME_W(FW), .FRAME_H(FH), .WIN(WIN), .GAP(0), .DATA_W(96)) dut_b (
        .CLK(clk), .RESET(rst), .START(start_b), .X0(in_x0), .Y0(in_y0),
        .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .MEM_RD(rd_b), .MEM_ADDR(maddr_b),
        .MEM_DATA(mdata_b), .CLS_START(cls_b), .XYZ_VALID(val_b), .ADDR(addr_b), .XYZ_out(xyz_b)
    );

    // Frame RAM contents: a salted function of the word address.
    function automatic logic [95:0] ram_word(input logic [18:0] a, input logic [31:0] s);
        return {s, s ^ 32'(a), 32'(a)};
    endfunction

    always_ff @(posedge clk) begin
        if (rd_a) mdata_a <= ram_word(maddr_a, salt);
        if (rd_b) mdata_b <= ram_word(maddr_b, salt);
    end

    // Expected outputs in cycle t after a launch at origin (ox,oy).
    // Layout: busy,done,err,mem_rd,valid,cls_start,mem_addr,addr,xyz.
    function automatic logic [VW-1:0] model(input int t, input int ox, input int oy,
                                            input int gap, input logic [31:0] s);
        int per, klast, r, c, k;
        logic b, d, rd, v, cs;
        logic [18:0] ma;
        logic [8:0]  ad;
        logic [95:0] xz;
        per   = WIN + gap;
        klast = (WIN - 1) * per + WIN - 1;
        b  = (t >= 0) && (t <= klast + 1);
        d  = (t == klast + 2);
        rd = 1'b0; ma = '0; v = 1'b0; ad = '0; xz = '0; cs = 1'b0;
        if (t >= 0 && t <= klast) begin
            r = t / per; c = t % per;
            if (c < WIN) begin
                rd = 1'b1;
                ma = 19'((oy + r) * FW + ox + c);
            end
        end
        if (t >= 1 && t - 1 <= klast) begin
            k = t - 1; r = k / per; c = k % per;
            if (c < WIN) begin
                v  = 1'b1;
                ad = 9'(c);
                xz = ram_word(19'((oy + r) * FW + ox + c), s);
                cs = (r == 0) && (c == 0);
            end
        end
        return {b, d, 1'b0, rd, v, cs, ma, ad, xz};
    endfunction

    function automatic logic [VW-1:0] obs(input bit sel);
        if (sel)
            return {busy_b, done_b, err_b, rd_b, val_b, cls_b,
                    rd_b ? maddr_b : 19'd0, val_b ? addr_b : 9'd0, val_b ? xyz_b : 96'd0};
        return {busy_a, done_a, err_a, rd_a, val_a, cls_a,
                rd_a ? maddr_a : 19'd0, val_a ? addr_a : 9'd0, val_a ? xyz_a : 96'd0};
    endfunction

    task automatic chk(input string tag, input int t, input logic [VW-1:0] o, input logic [VW-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %h expected %h", tag, t, o, e);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // Present START at a negedge; returns just after the accepting edge.
    task automatic launch(input bit sel, input int ox, input int oy);
        @(negedge clk);
        salt  = $urandom;
        in_x0 = 10'(ox);
        in_y0 = 9'(oy);
        set_start(sel, 1'b1);
        @(posedge clk);
    endtask

    task automatic run_window(input bit sel, input int ox, input int oy, input int gap,
                              input bit hold, input int intr_t, input int abort_t);
        int klast;
        logic [VW-1:0] o;
        klast = (WIN - 1) * (WIN + gap) + WIN - 1;
        for (int t = 0; t <= klast + 2; t++) begin
            @(negedge clk);
            o = obs(sel);
            chk("win", t, o, model(t, ox, oy, gap, salt));
            if (o[126]) last_ma  = o[123:105];
            if (o[125]) last_xyz = o[31:0];
            if (t == 0 && !hold) set_start(sel, 1'b0);
            if (t == intr_t) begin
                in_x0 = 10'((ox + 7) % 621);
                in_y0 = 9'((oy + 3) % 461);
                set_start(sel, 1'b1);
            end
            if (t == intr_t + 1) set_start(sel, 1'b0);
            if (t == abort_t) begin
                #1 rst = 1'b1;
                #1 chk("rst_async", t, obs(sel), '0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                for (int u = 0; u < 450; u++) begin
                    @(negedge clk);
                    chk("post_rst", u, obs(sel), '0);
                end
                return;
            end
        end
    endtask

    task automatic run_err(input int ox, input int oy);
        logic [VW-1:0] e;
        launch(1'b0, ox, oy);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            e = '0;
            e[127] = (t == 0);
            chk("err", t, obs(1'b0), e);
            if (t == 0) set_start(1'b0, 1'b0);
        end
    endtask

    initial begin
        int rx, ry;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        in_x0 = '0; in_y0 = '0; salt = '0;
        last_ma = '0; last_xyz = '0;
        #12;
        chk("reset_a", 0, obs(1'b0), '0);
        chk("reset_b", 0, obs(1'b1), '0);
        @(negedge clk);
        rst = 1'b0;

        // Origin (0,0).
        launch(1'b0, 0, 0);
        run_window(1'b0, 0, 0, 2, 1'b0, -10, -10);

        // Bottom-right corner origin.
        launch(1'b0, 620, 460);
        run_window(1'b0, 620, 460, 2, 1'b0, -10, -10);
        chk("corner_last_addr", 0, VW'(last_ma), VW'(307199));
        chk("corner_last_xyz", 0, VW'(last_xyz), VW'(307199));

        // Out-of-frame origins.
        run_err(621, 0);
        run_err(0, 461);

        // START while busy is ignored.
        rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
        launch(1'b0, rx, ry);
        run_window(1'b0, rx, ry, 2, 1'b0, 100, -10);

        // START held through DONE: back-to-back windows.
        rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
        launch(1'b0, rx, ry);
        run_window(1'b0, rx, ry, 2, 1'b1, -10, -10);
        run_window(1'b0, rx, ry, 2, 1'b0, -10, -10);

        // Random origins.
        for (int i = 0; i < 2; i++) begin
            rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
            launch(1'b0, rx, ry);
            run_window(1'b0, rx, ry, 2, 1'b0, -10, -10);
        end

        // Reset mid-window, then a full window after release.
        rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
        launch(1'b0, rx, ry);
        run_window(1'b0, rx, ry, 2, 1'b0, -10, 150);
        rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
        launch(1'b0, rx, ry);
        run_window(1'b0, rx, ry, 2, 1'b0, -10, -10);

        // GAP=0 instance: contiguous stream, DONE in cycle 401.
        rx = int'($urandom_range(620)); ry = int'($urandom_range(460));
        launch(1'b1, rx, ry);
        run_window(1'b1, rx, ry, 0, 1'b0, -10, -10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_streamer.md
# window_streamer

Transmit side of the classifier's line-buffer load interface. Given a window origin, the block reads a WIN×WIN pixel window from the synchronous frame RAM. It streams the window to the classifier one line at a time on ADDR/XYZ_out, with word index 0..WIN-1 per line. An inter-line gap lets the classifier finish its per-line integral update. The block sits between the frame RAM and the classifier and is launched by the scan controller once per window position.

## Interface
- FRAME_W, 640, frame width in pixels
- FRAME_H, 480, frame height in pixels
- WIN, 20, window side; words per line and lines per window
- GAP, 2, idle cycles inserted after each line except the last (0 allowed)
- DATA_W, 96, pixel word width (XYZ triple)

- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  launch request, sampled on the rising edge while idle
- X0  in  clog2(FRAME_W)  window origin column, sampled with START
- Y0  in  clog2(FRAME_H)  window origin row, sampled with START
- BUSY  out  1  high while a window is being streamed
- DONE  out  1  one-cycle pulse after the last word of the window
- ERR  out  1  one-cycle pulse when an out-of-frame origin is rejected
- MEM_RD  out  1  frame RAM read strobe
- MEM_ADDR  out  clog2(FRAME_W*FRAME_H)  frame RAM word address, computed as row*FRAME_W + col
- MEM_DATA  in  DATA_W  frame RAM read data, valid one cycle after MEM_RD
- CLS_START  out  1  pulse coincident with the first valid word of a window
- XYZ_VALID  out  1  XYZ_out/ADDR carry a word this cycle
- ADDR  out  9  word index within the current line, 0..WIN-1
- XYZ_out  out  DATA_W  pixel word to the classifier line buffer

## Operation
- States:
  - IDLE: waits for START.
  - ISSUE: issues one read per cycle.
  - GAP: issues no reads; counts down GAP cycles.
  - DRAIN: one cycle in which the final read returns.
- IDLE with START=1:
  - If X0 > FRAME_W-WIN or Y0 > FRAME_H-WIN: pulse ERR in the next cycle, issue no reads, and stay in IDLE.
  - Otherwise: latch the origin, load line_base = Y0*FRAME_W + X0, clear the row and column counters, and go to ISSUE.
- ISSUE:
  - Drive MEM_RD=1 and MEM_ADDR = line_base + col, then increment col.
  - At col = WIN-1: reset col to 0.
    - If row < WIN-1: line_base += FRAME_W, row += 1, and go to GAP (or directly to ISSUE if GAP=0).
    - If row = WIN-1: go to DRAIN.
- GAP: after GAP cycles, return to ISSUE.
- DRAIN: go to IDLE and pulse DONE.
- Read pipeline:
  - A one-stage pipeline registers (col, first-word flag) alongside each read.
  - In the cycle MEM_DATA returns: XYZ_VALID=1, XYZ_out=MEM_DATA, ADDR=col.
  - CLS_START=1 only for row 0, col 0.
- START while BUSY is ignored and the latched origin is unaffected.
- line_base is updated incrementally (no multiplier in the per-line path). The only multiply is the one-time Y0*FRAME_W at launch.
- All address arithmetic is unsigned. MEM_ADDR never exceeds FRAME_W*FRAME_H-1 for an accepted origin.

## Timing
- Reset values, all outputs: BUSY=0, DONE=0, ERR=0, MEM_RD=0, MEM_ADDR=0, CLS_START=0, XYZ_VALID=0, ADDR=0, XYZ_out=0. State is IDLE.
- RESET mid-window:
  - Outputs clear asynchronously and the pipeline stage is flushed.
  - No further XYZ_VALID is produced, and no DONE is produced for the aborted window.
- Cycle numbering: cycle 0 is the cycle following the edge that accepts START.
- Reads:
  - The read for (r,c) is presented in cycle k = r*(WIN+GAP) + c.
  - Its word appears on XYZ_out in cycle k+1.
- Last read: cycle k_last = (WIN-1)*(WIN+GAP) + WIN-1. The last valid word appears in cycle k_last+1.
- BUSY is high in cycles 0..k_last+1.
- In cycle k_last+2: DONE=1 and BUSY=0.
- A START sampled at the end of the DONE cycle is accepted, so windows can run back-to-back.
- With WIN=20 and GAP=2:
  - First valid word in cycle 1; last valid word in cycle 438; DONE in cycle 439.
  - Cycles per window from accept to DONE: 440.
- ERR is asserted in cycle 0 only, with BUSY remaining 0.
- XYZ_VALID is never high during the second and later cycles of a GAP.

## Test plan
- Origin (0,0), WIN=20, GAP=2, RAM word = address:
  - Expect 400 valid words, with row r/col c carrying value r*640+c.
  - ADDR cycles 0..19 on each line; CLS_START is high only in cycle 1; DONE in cycle 439.
- Origin (620,460), the bottom-right corner: accepted; the last MEM_ADDR is 307199 and the last XYZ_out is 307199.
- Origin (621,0), then origin (0,461): each produces ERR for one cycle in cycle 0, MEM_RD is never asserted, and BUSY stays 0.
- START pulsed again at cycle 100 with a different origin: ignored; the stream is unchanged and DONE still occurs in cycle 439.
- START held high through DONE: a second window begins in the cycle after DONE (MEM_RD=1); GAP=0 build gives contiguous 400 valid cycles, DONE at 401.
- RESET asserted in cycle 150 between clock edges:
  - All outputs are 0 immediately and there is no DONE.
  - After release, a new START produces a correct full window.
